// File: rtl/lp_dff_bank.sv
// Multi-bit low-power D-flop bank with load, scan shift and retention save/sleep/restore.
// Optional output isolation during low-power states is enabled by defining LP_DFF_ISO_EN.
module lp_dff_bank #(
    parameter int unsigned      WIDTH          = 8,
    parameter logic [WIDTH-1:0] RST_VAL        = '0,
    parameter int unsigned      SAVE_CYCLES    = 2,
    parameter int unsigned      RESTORE_CYCLES = 2,
    parameter logic [WIDTH-1:0] ISO_VAL        = '0
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             se,
    input  logic             si,
    output logic             so,
    output logic [WIDTH-1:0] q,
    input  logic             slp_req,
    output logic             slp_ack,
    output logic             rdy
);

    localparam int unsigned MAX_CYC = (SAVE_CYCLES > RESTORE_CYCLES) ? SAVE_CYCLES
                                                                     : RESTORE_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SAVE_LAST    = CNT_W'(SAVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESTORE_LAST = CNT_W'(RESTORE_CYCLES - 1);

`ifdef LP_DFF_ISO_EN
    localparam bit IsoEn = 1'b1;
`else
    localparam bit IsoEn = 1'b0;
`endif

    typedef enum logic [1:0] {StActive, StSave, StSleep, StRestore} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_val;

    // Single-bit banks have nothing to shift through; si loads directly.
    if (WIDTH == 1) begin : g_shift_w1
        assign shift_val = si;
    end else begin : g_shift_wn
        assign shift_val = {data_q[WIDTH-2:0], si};
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StActive: begin
                if (slp_req) begin
                    shadow_d = data_q;
                    cnt_d    = '0;
                    state_d  = StSave;
                end else if (se) begin
                    data_d = shift_val;
                end else if (en) begin
                    data_d = d;
                end
            end
            StSave: begin
                if (cnt_q == SAVE_LAST) begin
                    cnt_d   = '0;
                    state_d = StSleep;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSleep: begin
                if (!slp_req) begin
                    cnt_d   = '0;
                    state_d = StRestore;
                end
            end
            StRestore: begin
                if (cnt_q == RESTORE_LAST) begin
                    data_d  = shadow_q;
                    cnt_d   = '0;
                    state_d = StActive;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StActive;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q  <= StActive;
            data_q   <= RST_VAL;
            shadow_q <= RST_VAL;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        rdy     = (state_q == StActive);
        slp_ack = (state_q == StSleep);
        if (IsoEn && (state_q != StActive)) begin
            q  = ISO_VAL;
            so = 1'b0;
        end else begin
            q  = data_q;
            so = data_q[WIDTH-1];
        end
    end

endmodule
